// File: rtl/a2d_chan_monitor.sv
// rtl/a2d_chan_monitor.sv - round-robin A2D channel reader with averaging and hysteretic low flags
// Each round issues a command/read SPI pair per channel; averages publish every 2^AVG_LOG2 rounds.

module a2d_chan_monitor #(
  parameter int                  NUM_CH    = 4,
  parameter int                  DATA_W    = 12,
  parameter logic [NUM_CH*3-1:0] CH_ADDR   = {3'd5, 3'd4, 3'd6, 3'd0},
  parameter int                  AVG_LOG2  = 2,
  parameter logic [DATA_W-1:0]   LOW_THRES = DATA_W'('h800),
  parameter logic [DATA_W-1:0]   HYST      = DATA_W'('h040),
  parameter int                  TMO       = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nxt,
  output logic                     spi_wrt,
  output logic [15:0]              spi_cmd,
  input  logic                     spi_done,
  input  logic [15:0]              spi_resp,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_vld,
  output logic [NUM_CH-1:0]        low_flag,
  output logic                     round_done,
  output logic                     busy,
  output logic                     tmo_err
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMO_W = $clog2(TMO + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DATA_W:0]   CLR_SUM = {1'b0, LOW_THRES} + {1'b0, HYST};
  localparam logic [DATA_W-1:0] CLR_LVL = CLR_SUM[DATA_W] ? {DATA_W{1'b1}} : CLR_SUM[DATA_W-1:0];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_WAIT2 = 3'd5;
  localparam logic [2:0] S_ACC   = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  logic [2:0]               r_state;
  logic [CH_W-1:0]          r_ch;
  logic [ACC_W-1:0]         r_acc [NUM_CH];
  logic [CNT_W-1:0]         r_smp_cnt;
  logic [TMO_W-1:0]         r_tmo_cnt;
  logic [DATA_W-1:0]        r_sample;
  logic [15:0]              r_spi_cmd;
  logic [NUM_CH*DATA_W-1:0] r_ch_data;
  logic [NUM_CH-1:0]        r_ch_vld;
  logic [NUM_CH-1:0]        r_low_flag;
  logic                     r_tmo_err;

  logic                     w_in_wait;
  logic                     w_tmo_hit;
  logic                     w_last_ch;
  logic                     w_wrap;
  logic                     w_unused_resp;
  logic [ACC_W-1:0]         w_acc_sum [NUM_CH];
  logic [DATA_W-1:0]        w_avg [NUM_CH];

  function automatic logic [15:0] cmd_word(input logic [CH_W-1:0] ch);
    return {2'b00, CH_ADDR[3*int'(ch) +: 3], 11'h000};
  endfunction

  assign w_in_wait     = (r_state == S_WAIT1) || (r_state == S_WAIT2);
  assign w_tmo_hit     = w_in_wait && !spi_done && (r_tmo_cnt == TMO_W'(TMO - 1));
  assign w_last_ch     = (r_ch == CH_W'(NUM_CH - 1));
  assign w_wrap        = (AVG_LOG2 == 0) || (r_smp_cnt == CNT_W'((1 << AVG_LOG2) - 1));
  assign w_unused_resp = ^spi_resp[15:DATA_W];

  // Only the active channel gains the sample; this sum is what publishes on the last ACC.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_acc_sum[i] = r_acc[i] + ((r_ch == CH_W'(i)) ? ACC_W'(r_sample) : '0);
      w_avg[i]     = w_acc_sum[i][ACC_W-1:AVG_LOG2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_smp_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_sample   <= '0;
      r_spi_cmd  <= '0;
      r_ch_data  <= '0;
      r_ch_vld   <= '0;
      r_low_flag <= '0;
      r_tmo_err  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else begin
      r_ch_vld <= '0;
      case (r_state)
        S_IDLE: begin
          if (nxt) begin
            r_state   <= S_CMD;
            r_ch      <= '0;
            r_spi_cmd <= cmd_word('0);
          end
        end
        S_CMD: begin
          r_state   <= S_WAIT1;
          r_tmo_cnt <= '0;
        end
        S_WAIT1, S_WAIT2: begin
          if (spi_done) begin
            r_state <= (r_state == S_WAIT1) ? S_GAP : S_ACC;
            if (r_state == S_WAIT2) r_sample <= spi_resp[DATA_W-1:0];
          end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
            r_sample  <= '0;
            r_state   <= S_ACC;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        S_GAP: r_state <= S_READ;
        S_READ: begin
          r_state   <= S_WAIT2;
          r_tmo_cnt <= '0;
        end
        S_ACC: begin
          if (w_last_ch) begin
            r_state <= S_FIN;
            r_ch    <= '0;
            if (AVG_LOG2 > 0) r_smp_cnt <= r_smp_cnt + CNT_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
              if (w_wrap) begin
                r_acc[i]                       <= '0;
                r_ch_data[i*DATA_W +: DATA_W]  <= w_avg[i];
                r_ch_vld[i]                    <= 1'b1;
                if (w_avg[i] < LOW_THRES)     r_low_flag[i] <= 1'b1;
                else if (w_avg[i] >= CLR_LVL) r_low_flag[i] <= 1'b0;
              end else begin
                r_acc[i] <= w_acc_sum[i];
              end
            end
          end else begin
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= w_acc_sum[i];
            r_ch      <= r_ch + CH_W'(1);
            r_spi_cmd <= cmd_word(r_ch + CH_W'(1));
            r_state   <= S_CMD;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi_wrt    = (r_state == S_CMD) || (r_state == S_READ);
  assign spi_cmd    = r_spi_cmd;
  assign busy       = (r_state != S_IDLE) && (r_state != S_FIN);
  assign round_done = (r_state == S_FIN);
  assign ch_data    = r_ch_data;
  assign ch_vld     = r_ch_vld;
  assign low_flag   = r_low_flag;
  assign tmo_err    = r_tmo_err;

endmodule
